store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 st_valid  input  1  MEM stage presents a store this cycle.
REQ-005 st_type  input  2  store kind: 2'b00 sw, 2'b01 sh, 2'b10 sb, 2'b11 reserved (treated as no store).
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_data  input  32  register value to store (sb uses [7:0], sh uses [15:0]).
REQ-008 st_ready  output  1  buffer can accept a store this cycle.
REQ-009 st_err  output  1  one-cycle pulse: misaligned store rejected (AdES).
REQ-010 mem_wvalid  output  1  head entry is presented to data memory.
REQ-011 mem_waddr  output  32  word-aligned write address ({addr[31:2],2'b00}).
REQ-012 mem_wdata  output  32  lane-positioned write data.
REQ-013 mem_wbe  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-014 mem_wready  input  1  data memory accepts head entry this cycle.
REQ-015 ld_check  input  1  a load in MEM requests a hazard check.
REQ-016 ld_addr  input  32  byte address of that load.
REQ-017 ld_hazard  output  1  combinational: pending entry matches load word address; pipeline stalls.
REQ-018 empty  output  1  no pending entries (used before syscall/eret drain).

Function
REQ-019 Accept condition: st_valid && st_ready && st_type!=2'b11 && aligned; st_ready = (count < DEPTH), independent of same-cycle dequeue.
REQ-020 Alignment: sw requires addr[1:0]==0, sh requires addr[0]==0, sb always aligned; misaligned store with st_valid asserts st_err next cycle, is not enqueued.
REQ-021 Byte enables: sw 4'b1111; sh addr[1]=0 -> 4'b0011, addr[1]=1 -> 4'b1100; sb -> 4'b0001 << addr[1:0].
REQ-022 Write data: sw st_data; sh {2{st_data[15:0]}}; sb {4{st_data[7:0]}}.
REQ-023 Entries stored in circular FIFO (word address, data, be); read and write pointers wrap modulo DEPTH.
REQ-024 Latency: store accepted in cycle N appears on mem_wvalid no earlier than N+1; mem_w* driven from registered head entry only.
REQ-025 Handshake: head retires on cycle where mem_wvalid && mem_wready; mem_waddr/wdata/wbe stable while mem_wvalid && !mem_wready.
REQ-026 Simultaneous enqueue and dequeue: count unchanged, both pointers advance; order strictly FIFO.
REQ-027 mem_wvalid = !empty; empty = (count==0).
REQ-028 ld_hazard = ld_check && any valid entry with waddr[31:2]==ld_addr[31:2], including an entry retiring this cycle; excludes store being accepted this cycle.
REQ-029 Full: st_valid with st_ready=0 is ignored (no enqueue, no st_err); MEM stage must hold.

Reset
REQ-030 On rst_n low: count=0, pointers=0, mem_wvalid=0, st_ready=1, st_err=0, ld_hazard=0 (when ld_check low), empty=1.
REQ-031 Reset mid-operation discards all pending entries; an in-flight handshake is abandoned, no retry after reset.
REQ-032 Entry payload storage needs no reset; only valid/count/pointer state is reset.

Structure
REQ-033 Shared package holds st_type encodings (ST_SW, ST_SH, ST_SB) and BE constants (BE_WORD, BE_HALF_LO, BE_HALF_HI).
REQ-034 One sub-module store_align: combinational st_type/st_addr/st_data -> be, wdata, misaligned flag; instantiated once at the input.

Verification
REQ-035 sb addr 0x1003 data 0x000000AB -> next cycle mem_waddr 0x1000, mem_wbe 4'b1000, mem_wdata 0xABABABAB.
REQ-036 sh addr 0x2001 -> st_err pulse one cycle, empty stays 1, mem_wvalid stays 0.
REQ-037 Five sw with mem_wready=0, DEPTH=4 -> st_ready low after 4th, 5th not enqueued; release wready -> 4 writes in order.
REQ-038 Full buffer, st_valid and mem_wready same cycle -> no enqueue that cycle, one retire, st_ready high next cycle.
REQ-039 Pending sw 0x3000; load ld_addr 0x3002 -> ld_hazard=1; after retire -> ld_hazard=0.
REQ-040 rst_n low with 3 pending entries mid-handshake -> mem_wvalid 0 immediately, empty 1, no writes after release.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared store-type encodings, byte-enable constants and the buffered entry layout
// for the data-memory store write buffer.
package store_write_buffer_pkg;

  typedef enum logic [1:0] {
    ST_SW   = 2'b00,
    ST_SH   = 2'b01,
    ST_SB   = 2'b10,
    ST_RSVD = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Pipeline store port, data-memory write port and load hazard query of the store buffer.
interface store_write_buffer_if;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_err;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_wready;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  modport slave (
    input  st_valid, st_type, st_addr, st_data, mem_wready, ld_check, ld_addr,
    output st_ready, st_err, mem_wvalid, mem_waddr, mem_wdata, mem_wbe, ld_hazard, empty
  );

  modport master (
    output st_valid, st_type, st_addr, st_data, mem_wready, ld_check, ld_addr,
    input  st_ready, st_err, mem_wvalid, mem_waddr, mem_wdata, mem_wbe, ld_hazard, empty
  );
endinterface

// File: rtl/store_write_buffer_align.sv
// Combinational store formatter: lane-replicated write data, byte enables and
// misalignment detection for sw/sh/sb.
module store_align
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        is_store_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = '0;
    wdata_o      = st_data_i;
    is_store_o   = 1'b1;
    misaligned_o = 1'b0;
    case (st_type_e'(st_type_i))
      ST_SW: begin
        be_o         = BE_WORD;
        misaligned_o = |st_addr_i[1:0];
      end
      ST_SH: begin
        be_o         = st_addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o      = {2{st_data_i[15:0]}};
        misaligned_o = st_addr_i[0];
      end
      ST_SB: begin
        be_o    = BE_BYTE0 << st_addr_i[1:0];
        wdata_o = {4{st_data_i[7:0]}};
      end
      default: is_store_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Circular FIFO of formatted stores draining to data memory, with a load
// word-address hazard check against every pending entry.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  store_write_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_err_q, st_err_d;
  sb_entry_t     fifo_q [DEPTH];

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_is_store;
  logic        al_misaligned;

  store_align u_align (
    .st_type_i    (bus.st_type),
    .st_addr_i    (bus.st_addr),
    .st_data_i    (bus.st_data),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .is_store_o   (al_is_store),
    .misaligned_o (al_misaligned)
  );

  logic      st_ready;
  logic      enq, deq, attempt;
  sb_entry_t head;
  logic      hit;
  logic      unused_ld_lsb;

  assign st_ready = (count_q < CW'(DEPTH));
  assign attempt  = bus.st_valid && st_ready && al_is_store;
  assign enq      = attempt && !al_misaligned;
  assign deq      = (count_q != '0) && bus.mem_wready;
  assign head     = fifo_q[rd_ptr_q];
  assign unused_ld_lsb = ^bus.ld_addr[1:0];

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    st_err_d = attempt && al_misaligned;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  // Payload carries no reset; validity comes solely from count/pointers.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= '{waddr: bus.st_addr[31:2], wdata: al_wdata, be: al_be};
  end

  // An entry is live when its distance from the read pointer is below count,
  // so the retiring head still counts and the store being accepted does not.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(PW'(i) - rd_ptr_q) < count_q && fifo_q[i].waddr == bus.ld_addr[31:2])
        hit = 1'b1;
    end
  end

  assign bus.st_ready   = st_ready;
  assign bus.st_err     = st_err_q;
  assign bus.empty      = (count_q == '0);
  assign bus.mem_wvalid = (count_q != '0);
  assign bus.mem_waddr  = {head.waddr, 2'b00};
  assign bus.mem_wdata  = head.wdata;
  assign bus.mem_wbe    = head.be;
  assign bus.ld_hazard  = bus.ld_check && hit;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: formatting vectors from a table plus
// hand-written full/drain, hazard and reset sequences.
module tb_store_write_buffer;
  import store_write_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_write_buffer_if bus ();

  store_write_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] addr;
    logic [31:0] data;
    logic        enq;
    logic        err;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.st_type  = ST_SW;
    bus.st_addr  = '0;
    bus.st_data  = '0;
  endtask

  task automatic put(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_type  = t;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  initial begin
    vecs[0] = '{ST_SW,   32'h0000_1000, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678, 4'b1111};
    vecs[1] = '{ST_SH,   32'h0000_2002, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
    vecs[2] = '{ST_SH,   32'h0000_2000, 32'hAAAA_1234, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_1234, 4'b0011};
    vecs[3] = '{ST_SB,   32'h0000_1003, 32'h0000_00AB, 1'b1, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[4] = '{ST_SB,   32'h0000_1001, 32'h5566_7788, 1'b1, 1'b0, 32'h0000_1000, 32'h8888_8888, 4'b0010};
    vecs[5] = '{ST_SH,   32'h0000_2001, 32'h0000_1111, 1'b0, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[6] = '{ST_SW,   32'h0000_3002, 32'h2222_2222, 1'b0, 1'b1, 32'h0,         32'h0,         4'b0000};
    vecs[7] = '{ST_RSVD, 32'h0000_4000, 32'h3333_3333, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000};

    rst_n = 1'b0;
    idle();
    bus.mem_wready = 1'b0;
    bus.ld_check   = 1'b0;
    bus.ld_addr    = '0;
    step();
    step();
    check("rst_wvalid",  bus.mem_wvalid, 0);
    check("rst_empty",   bus.empty,      1);
    check("rst_ready",   bus.st_ready,   1);
    check("rst_err",     bus.st_err,     0);
    check("rst_hazard",  bus.ld_hazard,  0);
    rst_n = 1'b1;
    step();

    // Formatting vectors: one store, inspect head, drain it.
    for (int i = 0; i < 8; i++) begin
      put(vecs[i].t, vecs[i].addr, vecs[i].data);
      step();
      idle();
      check($sformatf("v%0d_err", i),    bus.st_err,     vecs[i].err);
      check($sformatf("v%0d_wvalid", i), bus.mem_wvalid, vecs[i].enq);
      check($sformatf("v%0d_empty", i),  bus.empty,      !vecs[i].enq);
      if (vecs[i].enq) begin
        check($sformatf("v%0d_waddr", i), bus.mem_waddr, vecs[i].waddr);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].wdata);
        check($sformatf("v%0d_wbe", i),   bus.mem_wbe,   vecs[i].be);
        bus.mem_wready = 1'b1;
      end
      step();
      bus.mem_wready = 1'b0;
      check($sformatf("v%0d_err_clr", i), bus.st_err, 0);
      check($sformatf("v%0d_drained", i), bus.empty,  1);
    end

    // Five stores into a 4-deep buffer with memory stalled.
    for (int i = 0; i < 5; i++) begin
      put(ST_SW, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      check($sformatf("fill%0d_ready", i), bus.st_ready, (i < 4) ? 1 : 0);
      step();
    end
    idle();
    check("full_ready",  bus.st_ready,  0);
    check("full_err",    bus.st_err,    0);
    check("full_head",   bus.mem_waddr, 32'h100);
    check("full_hdata",  bus.mem_wdata, 32'hA0);

    // Store offered while full in the same cycle the head retires.
    put(ST_SW, 32'h300, 32'hDEAD);
    bus.mem_wready = 1'b1;
    #1;
    check("fullret_ready_pre", bus.st_ready, 0);
    step();
    idle();
    check("fullret_ready_post", bus.st_ready, 1);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("drain%0d_wvalid", k), bus.mem_wvalid, 1);
      check($sformatf("drain%0d_waddr", k),  bus.mem_waddr,  32'h100 + 32'(4 * k));
      check($sformatf("drain%0d_wdata", k),  bus.mem_wdata,  32'hA0 + 32'(k));
      step();
    end
    bus.mem_wready = 1'b0;
    check("drain_empty", bus.empty, 1);

    // Load hazard against a pending word.
    put(ST_SW, 32'h3000, 32'h1);
    step();
    idle();
    bus.ld_check = 1'b1;
    bus.ld_addr  = 32'h3002;
    #1;
    check("hz_match", bus.ld_hazard, 1);
    bus.ld_addr = 32'h3004;
    #1;
    check("hz_other_word", bus.ld_hazard, 0);
    bus.ld_check = 1'b0;
    bus.ld_addr  = 32'h3000;
    #1;
    check("hz_no_check", bus.ld_hazard, 0);
    bus.ld_check   = 1'b1;
    bus.mem_wready = 1'b1;
    #1;
    check("hz_retiring", bus.ld_hazard, 1);
    step();
    bus.mem_wready = 1'b0;
    check("hz_after_retire", bus.ld_hazard, 0);
    check("hz_empty", bus.empty, 1);

    put(ST_SW, 32'h5000, 32'h2);
    bus.ld_addr = 32'h5001;
    #1;
    check("hz_same_cycle_accept", bus.ld_hazard, 0);
    step();
    idle();
    check("hz_next_cycle", bus.ld_hazard, 1);
    bus.mem_wready = 1'b1;
    step();
    bus.mem_wready = 1'b0;
    bus.ld_check   = 1'b0;
    check("hz_seq_empty", bus.empty, 1);

    // Reset while three entries are pending and memory is accepting.
    for (int i = 0; i < 3; i++) begin
      put(ST_SW, 32'h600 + 32'(4 * i), 32'hC0 + 32'(i));
      step();
    end
    idle();
    check("rst2_pre_wvalid", bus.mem_wvalid, 1);
    bus.mem_wready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_wvalid", bus.mem_wvalid, 0);
    check("rst2_empty",  bus.empty,      1);
    check("rst2_ready",  bus.st_ready,   1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst2_post%0d_wvalid", i), bus.mem_wvalid, 0);
    end
    bus.mem_wready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
